uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive-side buffer that sits directly downstream of the UART receiving unit.
- Watches the receiver's byte-available flag and captures each received byte into a DEPTH-entry FIFO.
- Pulses the receiver's read-over input so the receiver clears its flag for the next byte.
- Presents the buffered bytes to the CPU/bridge through a show-ahead pop interface with count, full and overrun status.

Parameters:
- DEPTH, 16, number of FIFO entries; must be a power of two, >= 2.
- AW, 4, pointer width; log2(DEPTH).
- THRESH, 8, fill level that raises irq; used only with UART_RX_FIFO_IRQ_EN; valid range 1..DEPTH.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- rx_data  in  8  received byte from the receiver's d_out.
- rx_rs  in  1  receiver status (byte available) from the receiver's rs.
- rx_over_read  out  1  byte-consumed pulse to the receiver's over_read.
- rd_en  in  1  pop request from the CPU side.
- rd_data  out  8  head-of-FIFO byte; show-ahead.
- rd_valid  out  1  FIFO not empty.
- full  out  1  FIFO holds DEPTH bytes.
- count  out  AW+1  current fill level, 0..DEPTH.
- overrun  out  1  sticky flag: a byte was lost.
- clr_overrun  in  1  clears overrun.
- irq  out  1  threshold/overrun interrupt; only active with UART_RX_FIFO_IRQ_EN.

Behaviour:
- Reset (synchronous): state=IDLE; wptr=rptr=0; count=0; rx_over_read=0; overrun=0; rs_q=0. Outputs after reset: rd_valid=0, full=0, rd_data=mem[0] (don't-care), irq=0.
- rs_q is rx_rs registered once. All capture decisions use rs_q.
- Capture FSM:
  - IDLE: on an edge with rs_q=1, act on rx_data at that edge, then go to ACK.
    - If the FIFO is not full, or is full with a concurrent rd_en pop: write mem[wptr] and increment wptr.
    - Otherwise: drop the byte and set overrun.
  - ACK: rx_over_read=1 for exactly this one cycle (registered output). Go to WAIT_CLR.
  - WAIT_CLR: rx_over_read=0. Stay until rs_q=0, then go to IDLE. This guarantees one capture per receiver byte.
  - Illegal state: go to IDLE.
- Latency: rx_rs rises at cycle t → byte written at the edge ending t+1 → rd_valid=1 in cycle t+2 → rx_over_read high in cycle t+2.
- Pop:
  - rd_en with rd_valid=1 increments rptr at the edge.
  - rd_en with rd_valid=0 is ignored; no pointer or count change.
  - rd_data = mem[rptr] combinationally.
- count: +1 on write only, -1 on pop only, unchanged on simultaneous write+pop.
  - full = (count==DEPTH); rd_valid = (count!=0).
- Pointers wrap modulo DEPTH; no special case at DEPTH-1→0.
- overrun: set on a dropped byte; cleared by clr_overrun. If set and clear occur in the same cycle, set wins.
- A dropped byte still gets the ACK pulse, so the receiver is never stalled.
- Reset mid-operation: all state returns to reset values and buffered data is discarded.
  - If rx_rs is still 1 after reset, that byte is captured again; this is the required behaviour.

Optional Feature:
- Macro: UART_RX_FIFO_IRQ_EN.
- Defined: irq is registered; irq = (count >= THRESH) || overrun, evaluated on next-state values so irq tracks count with zero extra cycle.
- Not defined: irq is tied 0 and THRESH is unused. All other behaviour is identical.

Test Plan:
- Single byte: rx_data=8'hA5, rx_rs raised at cycle 10 → rx_over_read high in cycle 12 only; rd_valid=1, rd_data=8'hA5, count=1; rd_en one cycle → count=0, rd_valid=0.
- Ordering/wrap: push 20 bytes 8'h00..8'h13, popping after every 4 pushes → rd_data sequence 00..13 in order across pointer wrap, no overrun.
- Full/overrun: push 17 bytes with no pops → full=1 after byte 16, byte 17 (8'h10) dropped, overrun=1, rx_over_read still pulsed, count=16; clr_overrun → overrun=0.
- Simultaneous at full: count=16 with rd_en asserted on the capture edge → write accepted, count stays 16, overrun=0; set/clear collision: drop plus clr_overrun in the same cycle → overrun=1.
- Held flag: rx_rs held high for 50 cycles → exactly one capture and one rx_over_read pulse; FSM in WAIT_CLR until rx_rs=0.
- Reset mid-stream: 3 bytes buffered, rst high 1 cycle → count=0, rd_valid=0, overrun=0, rx_over_read=0. With UART_RX_FIFO_IRQ_EN and THRESH=8: 8th byte → irq=1; one pop → irq=0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO between a UART receiver and the CPU: captures each byte
// flagged by rx_rs, acknowledges it with rx_over_read, and offers show-ahead pops.
// Optional threshold/overrun interrupt enabled by defining UART_RX_FIFO_IRQ_EN.
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int THRESH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_rs,
    output logic          rx_over_read,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overrun,
    input  logic          clr_overrun,
    output logic          irq
);

    typedef enum logic [1:0] {IDLE, ACK, WAIT_CLR} state_t;

    state_t        state, state_next;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count_next;
    logic          rs_q;
    logic          over_read_next;
    logic          capture, do_pop, do_write, do_drop, overrun_next;

    if (DEPTH < 2 || (1 << AW) != DEPTH || THRESH < 1 || THRESH > DEPTH) begin : g_param_check
        $error("uart_rx_fifo: inconsistent DEPTH/AW/THRESH");
    end

    assign rd_valid = (count != '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign rd_data  = mem[rptr];

    // A full FIFO can still accept a byte when a pop frees a slot on the same edge.
    assign do_pop   = rd_en && rd_valid;
    assign capture  = (state == IDLE) && rs_q;
    assign do_write = capture && (!full || do_pop);
    assign do_drop  = capture && !do_write;

    assign overrun_next = do_drop ? 1'b1 : (clr_overrun ? 1'b0 : overrun);

    always_comb begin
        count_next = count;
        case ({do_write, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rx_over_read <= 1'b0;
        end else begin
            state        <= state_next;
            rx_over_read <= over_read_next;
        end
    end

    // WAIT_CLR holds off until the receiver drops its flag, so one byte is taken once.
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:     state_next = rs_q ? ACK : IDLE;
            ACK:      state_next = WAIT_CLR;
            WAIT_CLR: state_next = rs_q ? WAIT_CLR : IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        over_read_next = (state_next == ACK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            overrun <= 1'b0;
            rs_q    <= 1'b0;
        end else begin
            rs_q    <= rx_rs;
            count   <= count_next;
            overrun <= overrun_next;
            if (do_write) wptr <= wptr + 1'b1;
            if (do_pop)   rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem[wptr] <= rx_data;
    end

`ifdef UART_RX_FIFO_IRQ_EN
    localparam logic [AW:0] THRESH_W = (AW+1)'(THRESH);

    // Built from next-state values so irq changes on the same edge as count.
    always_ff @(posedge clk) begin
        if (rst) irq <= 1'b0;
        else     irq <= (count_next >= THRESH_W) || overrun_next;
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a receiver model drives bytes, a monitor
// checks every popped byte against the expected queue.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_rs;
    logic          rx_over_read;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          full;
    logic [AW:0]   count;
    logic          overrun;
    logic          clr_overrun;
    logic          irq;

    int            vecCount  = 0;
    int            missCount = 0;
    logic [7:0]    expQ[$];
    int            modelCount = 0;
    logic          expOverrun = 1'b0;

    uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .THRESH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_rs        (rx_rs),
        .rx_over_read (rx_over_read),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .count        (count),
        .overrun      (overrun),
        .clr_overrun  (clr_overrun),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples mid low-phase, when a pop is being requested on a valid head.
    always begin
        @(negedge clk);
        #2;
        if (!rst && rd_en && rd_valid) begin
            vecCount++;
            if (expQ.size() == 0) begin
                missCount++;
                $display("[TB] FAIL pop_underflow: got %0h, expected no data", rd_data);
            end else begin
                logic [7:0] e;
                e = expQ.pop_front();
                if (rd_data !== e) begin
                    missCount++;
                    $display("[TB] FAIL pop_data: got %0h, expected %0h", rd_data, e);
                end
            end
        end
    end

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expQ.delete();
        modelCount = 0;
        expOverrun = 1'b0;
    endtask

    // Receiver model: raise rx_rs, optionally pop/clear on the capture edge, hold, release.
    task automatic applyStimulus(input logic [7:0] d, input bit popCap, input bit clrCap, input int hold);
        int pulses;
        bit popValid, accepted;
        pulses   = 0;
        popValid = popCap && (modelCount > 0);
        accepted = (modelCount < DEPTH) || popValid;
        if (accepted) expQ.push_back(d);
        @(negedge clk);
        rx_data = d;
        rx_rs   = 1'b1;
        @(negedge clk);
        rd_en       = popCap;
        clr_overrun = clrCap;
        checkOutput("ack_early", rx_over_read, 0);
        @(negedge clk);
        rd_en       = 1'b0;
        clr_overrun = 1'b0;
        checkOutput("ack_latency", rx_over_read, 1);
        pulses += rx_over_read;
        repeat (hold) begin
            @(negedge clk);
            pulses += rx_over_read;
        end
        rx_rs = 1'b0;
        repeat (2) begin
            @(negedge clk);
            pulses += rx_over_read;
        end
        checkOutput("ack_pulses", pulses, 1);
        modelCount = modelCount + (accepted ? 1 : 0) - (popValid ? 1 : 0);
        if (!accepted)   expOverrun = 1'b1;
        else if (clrCap) expOverrun = 1'b0;
        checkOutput("count", count, modelCount);
        checkOutput("overrun", overrun, expOverrun);
        checkOutput("full", full, (modelCount == DEPTH));
    endtask

    task automatic popN(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rd_en = 1'b1;
        end
        @(negedge clk);
        rd_en = 1'b0;
        modelCount -= n;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_rs = 1'b0; rd_en = 1'b0; clr_overrun = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_count", count, 0);
        checkOutput("reset_valid", rd_valid, 0);
        checkOutput("reset_full", full, 0);
        checkOutput("reset_overrun", overrun, 0);
        checkOutput("reset_ack", rx_over_read, 0);
        checkOutput("reset_irq", irq, 0);
        repeat (5) @(negedge clk);

        // Single byte then pop
        applyStimulus(8'hA5, 0, 0, 0);
        checkOutput("single_valid", rd_valid, 1);
        checkOutput("single_head", rd_data, 8'hA5);
        popN(1);
        checkOutput("single_count", count, 0);
        checkOutput("single_empty", rd_valid, 0);

        // Ordering across pointer wrap
        doReset();
        for (int g = 0; g < 5; g++) begin
            for (int k = 0; k < 4; k++) applyStimulus(8'(g*4 + k), 0, 0, 0);
            popN(4);
        end
        checkOutput("wrap_count", count, 0);
        checkOutput("wrap_overrun", overrun, 0);

        // Fill, overflow, clear
        doReset();
        for (int k = 0; k < 16; k++) applyStimulus(8'(k), 0, 0, 0);
        checkOutput("fill_full", full, 1);
        applyStimulus(8'h10, 0, 0, 0);
        checkOutput("drop_overrun", overrun, 1);
        checkOutput("drop_count", count, 16);
`ifndef UART_RX_FIFO_IRQ_EN
        checkOutput("irq_tied", irq, 0);
`else
        checkOutput("irq_overrun", irq, 1);
`endif
        @(negedge clk); clr_overrun = 1'b1;
        @(negedge clk); clr_overrun = 1'b0;
        expOverrun = 1'b0;
        checkOutput("clr_overrun", overrun, 0);
        popN(16);
        checkOutput("drain_empty", rd_valid, 0);

        // Write with concurrent pop at full, then set/clear collision
        doReset();
        for (int k = 0; k < 16; k++) applyStimulus(8'(8'h20 + k), 0, 0, 0);
        applyStimulus(8'h30, 1, 0, 0);
        checkOutput("simul_count", count, 16);
        checkOutput("simul_overrun", overrun, 0);
        applyStimulus(8'h31, 0, 1, 0);
        checkOutput("collision_overrun", overrun, 1);
        popN(16);

        // Held receiver flag gives exactly one capture
        doReset();
        applyStimulus(8'h5C, 0, 0, 50);
        checkOutput("held_count", count, 1);
        popN(1);

        // Reset while data is buffered
        doReset();
        for (int k = 0; k < 3; k++) applyStimulus(8'(8'hB0 + k), 0, 0, 0);
        doReset();
        checkOutput("midrst_count", count, 0);
        checkOutput("midrst_valid", rd_valid, 0);
        checkOutput("midrst_overrun", overrun, 0);
        checkOutput("midrst_ack", rx_over_read, 0);

`ifdef UART_RX_FIFO_IRQ_EN
        for (int k = 0; k < 7; k++) applyStimulus(8'(8'hC0 + k), 0, 0, 0);
        checkOutput("irq_below", irq, 0);
        applyStimulus(8'hC7, 0, 0, 0);
        checkOutput("irq_thresh", irq, 1);
        popN(1);
        checkOutput("irq_drop", irq, 0);
        popN(7);
`endif

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_left", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
